// File: rtl/mux_arbitro_pkg.sv
// mux_arbitro_pkg: shared constants for the arbitrating multiplexer.
//   MODO_FIJO / MODO_RR : values of the 'modo' input.
//   IDLE / SERVICIO / ESPERA : controller state encodings.
//   ancho_canal()       : width of a channel index (never less than 1).
package mux_arbitro_pkg;

  localparam logic MODO_FIJO = 1'b0;
  localparam logic MODO_RR   = 1'b1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SERVICIO = 2'd1;
  localparam logic [1:0] ESPERA   = 2'd2;

  function automatic int ancho_canal(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arbitro_if.sv
// mux_arbitro_if: upstream/downstream FIFO signals of mux_arbitro.
//   entradas : flattened head words, channel i at [i*DATA_BITS +: DATA_BITS]
//   vacio    : per-channel upstream empty flag
//   pop      : per-channel pop strobe (at most one bit set)
//   lleno    : downstream FIFO full
//   salida   : registered data word towards the downstream FIFO
//   push     : registered write strobe
//   canal    : registered index of the channel that sourced salida
// modport slave is the multiplexer's view, modport master the environment's.
interface mux_arbitro_if
  import mux_arbitro_pkg::*;
#(
  parameter int DATA_BITS = 6,
  parameter int N_CANALES = 4
);
  localparam int CW = ancho_canal(N_CANALES);

  logic [N_CANALES*DATA_BITS-1:0] entradas;
  logic [N_CANALES-1:0]           vacio;
  logic [N_CANALES-1:0]           pop;
  logic                           lleno;
  logic [DATA_BITS-1:0]           salida;
  logic                           push;
  logic [CW-1:0]                  canal;

  modport slave (
    input  entradas, vacio, lleno,
    output pop, salida, push, canal
  );

  modport master (
    output entradas, vacio, lleno,
    input  pop, salida, push, canal
  );

endinterface

// File: rtl/mux_arbitro_arbitro_rr.sv
// arbitro_rr: combinational channel search.
//   vacio      : per-channel empty flags
//   inicio     : first channel examined in round-robin mode
//   modo       : MODO_FIJO searches from channel 0, MODO_RR from inicio
//   sel        : first non-empty channel in search order (0 if none)
//   encontrado : at least one channel is non-empty
module arbitro_rr
  import mux_arbitro_pkg::*;
#(
  parameter  int N_CANALES = 4,
  localparam int CW        = ancho_canal(N_CANALES)
) (
  input  logic [N_CANALES-1:0] vacio,
  input  logic [CW-1:0]        inicio,
  input  logic                 modo,
  output logic [CW-1:0]        sel,
  output logic                 encontrado
);

  int unsigned base;
  int unsigned idx;

  always_comb begin
    sel        = '0;
    encontrado = 1'b0;
    idx        = 0;
    base       = (modo == MODO_RR) ? int'(inicio) : 0;
    for (int unsigned k = 0; k < N_CANALES; k++) begin
      idx = (base + k) % N_CANALES;
      if (!encontrado && !vacio[idx[CW-1:0]]) begin
        sel        = idx[CW-1:0];
        encontrado = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbitro.sv
// mux_arbitro: N-channel arbitrating multiplexer draining upstream FIFOs
// into one downstream FIFO.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   enb   : block enable (0 = no pops, no pushes)
//   modo  : MODO_FIJO = lowest index wins, MODO_RR = round robin with
//           bursts of up to MAX_RAFAGA words per grant
//   bus   : FIFO-side signals (mux_arbitro_if.slave)
// A pop in cycle t yields push/salida/canal at the edge ending cycle t.
module mux_arbitro
  import mux_arbitro_pkg::*;
#(
  parameter int DATA_BITS  = 6,
  parameter int N_CANALES  = 4,
  parameter int MAX_RAFAGA = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          enb,
  input logic          modo,
  mux_arbitro_if.slave bus
);

  localparam int CW    = ancho_canal(N_CANALES);
  localparam int CNT_W = $clog2(MAX_RAFAGA + 1);

  logic [1:0]           estado, estado_sig;
  logic [CW-1:0]        puntero;
  logic [CW-1:0]        inicio;
  logic [CW-1:0]        sel;
  logic [CNT_W-1:0]     contador;
  logic                 hay_datos;
  logic                 encontrado;
  logic                 grant;
  logic                 mantener;
  logic [DATA_BITS-1:0] dato_sel;

  assign hay_datos = ~&bus.vacio;
  assign grant     = enb & ~bus.lleno & ~reset & encontrado;

  // Keeping the owner is expressed as a search that starts at the owner
  // itself; otherwise the search starts one past it and wraps, which also
  // re-grants the owner last when every other channel is empty.
  assign mantener = (modo == MODO_RR) && !bus.vacio[puntero] &&
                    (contador < CNT_W'(MAX_RAFAGA));

  always_comb begin
    if (mantener)
      inicio = puntero;
    else if (puntero == CW'(N_CANALES - 1))
      inicio = '0;
    else
      inicio = puntero + CW'(1);
  end

  arbitro_rr #(
    .N_CANALES (N_CANALES)
  ) u_arbitro_rr (
    .vacio      (bus.vacio),
    .inicio     (inicio),
    .modo       (modo),
    .sel        (sel),
    .encontrado (encontrado)
  );

  always_comb begin
    bus.pop = '0;
    if (grant)
      bus.pop[sel] = 1'b1;
  end

  always_comb begin
    dato_sel = '0;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      if (sel == CW'(i))
        dato_sel = bus.entradas[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE: begin
        if (grant)
          estado_sig = SERVICIO;
      end
      SERVICIO, ESPERA: begin
        if (grant)
          estado_sig = SERVICIO;
        else if (enb && hay_datos && bus.lleno)
          estado_sig = ESPERA;
        else
          estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= IDLE;
      puntero    <= '0;
      contador   <= '0;
      bus.salida <= '0;
      bus.push   <= 1'b0;
      bus.canal  <= '0;
    end else begin
      estado   <= estado_sig;
      bus.push <= grant;
      if (grant) begin
        bus.salida <= dato_sel;
        bus.canal  <= sel;
        puntero    <= sel;
      end
      // Fixed mode keeps the counter at zero so a later switch to round
      // robin starts a fresh burst on the last fixed-priority owner.
      if (modo == MODO_FIJO)
        contador <= '0;
      else if (grant)
        contador <= mantener ? contador + CNT_W'(1) : CNT_W'(1);
    end
  end

endmodule
